// File: rtl/led_share_pkg.sv
// Shared types and constants for the LED sharing controller.
package led_share_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t LED_OFF    = 2'd0;
  localparam mode_t LED_ON     = 2'd1;
  localparam mode_t LED_BLINK  = 2'd2;
  localparam mode_t LED_BREATH = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

endpackage

// File: rtl/led_share_ctrl_if.sv
// Requester/LED bundle for led_share_ctrl: master drives requests, slave returns grant and LED.
interface led_share_ctrl_if #(
  parameter int unsigned NUM_REQ = 4
);
  import led_share_pkg::*;

  logic                      i_en;
  logic [NUM_REQ-1:0]        i_req;
  logic [MODE_W*NUM_REQ-1:0] i_mode;
  logic [NUM_REQ-1:0]        o_grant;
  logic                      o_busy;
  mode_t                     o_mode;
  logic                      o_led;

  modport master (
    output i_en, i_req, i_mode,
    input  o_grant, o_busy, o_mode, o_led
  );

  modport slave (
    input  i_en, i_req, i_mode,
    output o_grant, o_busy, o_mode, o_led
  );

endinterface

// File: rtl/led_pattern_gen.sv
// Blink / breathe pattern generator for the granted requester.
// Define LED_GAMMA_EN to square the breath compare value (perceptual gamma).
module led_pattern_gen
  import led_share_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DUTY_W  = 21,
  parameter int unsigned BLINK_W = 24
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_clear,
  input  mode_t i_mode,
  output logic  o_pat
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  logic [BLINK_W-1:0] r_blink;
  logic [CNT_W-1:0]   r_pwm;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_up;

  logic               w_up;
  logic [CNT_W-1:0]   w_d;
  logic [CNT_W-1:0]   w_cmp;
  logic [2*CNT_W-1:0] w_sq;

  // Direction flips in the same cycle the ramp touches either end.
  always_comb begin
    w_up = r_up;
    if (r_duty == '0) begin
      w_up = 1'b1;
    end else if (r_duty == DUTY_MAX) begin
      w_up = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_blink <= '0;
      r_pwm   <= '0;
      r_duty  <= '0;
      r_up    <= 1'b1;
    end else begin
      r_blink <= r_blink + BLINK_W'(1);
      r_pwm   <= r_pwm + CNT_W'(1);
      r_duty  <= w_up ? r_duty + DUTY_W'(1) : r_duty - DUTY_W'(1);
      r_up    <= w_up;
    end
  end

  always_comb begin
    w_d  = r_duty[DUTY_W-1 -: CNT_W];
    w_sq = {{CNT_W{1'b0}}, w_d} * {{CNT_W{1'b0}}, w_d};
`ifdef LED_GAMMA_EN
    w_cmp = w_sq[2*CNT_W-1:CNT_W];
`else
    w_cmp = w_d;
`endif
  end

  always_comb begin
    o_pat = 1'b0;
    unique case (i_mode)
      LED_OFF:    o_pat = 1'b0;
      LED_ON:     o_pat = 1'b1;
      LED_BLINK:  o_pat = ~r_blink[BLINK_W-1];
      LED_BREATH: o_pat = (r_pwm < w_cmp);
      default:    o_pat = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_share_ctrl.sv
// Fixed-priority LED arbiter with minimum hold time; drives the granted requester's pattern.
// Optional LED_GAMMA_EN (in led_pattern_gen) gamma-corrects the breath ramp.
module led_share_ctrl
  import led_share_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DUTY_W   = 21,
  parameter int unsigned BLINK_W  = 24,
  parameter int unsigned HOLD_CYC = 65536
) (
  input logic             i_clk,
  input logic             i_rst,
  led_share_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  state_e              r_state, w_state_d;
  logic [IDX_W-1:0]    r_idx, w_idx_d;
  logic [HOLD_W-1:0]   r_hold, w_hold_d;
  logic                r_led, w_led_d;

  logic                w_any;
  logic [IDX_W-1:0]    w_low;
  logic                w_load;
  logic                w_clear;
  logic                w_pat;
  mode_t               w_mode;

  always_comb begin
    w_any = 1'b0;
    w_low = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.i_req[i]) begin
        w_any = 1'b1;
        w_low = IDX_W'(i);
      end
    end
  end

  assign w_mode  = bus.i_mode[MODE_W*r_idx +: MODE_W];
  assign w_clear = w_load || (r_state == ST_IDLE);

  led_pattern_gen #(
    .CNT_W   (CNT_W),
    .DUTY_W  (DUTY_W),
    .BLINK_W (BLINK_W)
  ) u_pattern (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_mode  (w_mode),
    .o_pat   (w_pat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_hold  <= w_hold_d;
      r_led   <= w_led_d;
    end
  end

  // Release wins over preemption; any grant change blanks the LED for one cycle.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_hold_d  = r_hold;
    w_load    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_en && w_any) begin
          w_state_d = ST_ACTIVE;
          w_idx_d   = w_low;
          w_load    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!bus.i_en || !bus.i_req[r_idx]) begin
          w_state_d = ST_IDLE;
        end else if ((r_hold == '0) && (w_low < r_idx)) begin
          w_idx_d = w_low;
          w_load  = 1'b1;
        end else if (r_hold != '0) begin
          w_hold_d = r_hold - HOLD_W'(1);
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (w_load) begin
      w_hold_d = HOLD_LOAD;
    end
    w_led_d = (r_state == ST_ACTIVE) && (w_state_d == ST_ACTIVE) && !w_load && w_pat;
  end

  always_comb begin
    bus.o_grant = '0;
    bus.o_busy  = 1'b0;
    bus.o_mode  = LED_OFF;
    bus.o_led   = r_led;
    if (r_state == ST_ACTIVE) begin
      bus.o_grant[r_idx] = 1'b1;
      bus.o_busy         = 1'b1;
      bus.o_mode         = w_mode;
    end
  end

endmodule

// File: tb/tb_led_share_ctrl.sv
// Scoreboard bench for led_share_ctrl: directed test-plan sequence then random phases.
module tb_led_share_ctrl;
  import led_share_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned DW   = 6;
  localparam int unsigned BW   = 3;
  localparam int unsigned HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_share_ctrl_if #(.NUM_REQ(NREQ)) bus ();

  led_share_ctrl #(
    .NUM_REQ  (NREQ),
    .CNT_W    (CW),
    .DUTY_W   (DW),
    .BLINK_W  (BW),
    .HOLD_CYC (HOLD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic [1:0] mode;
    logic       led;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: granted index (-1 = none), hold left, cycles since grant, registered LED.
  int m_g = -1;
  int m_h = 0;
  int m_t = 0;
  bit m_led = 1'b0;

  function automatic bit ref_pat(input int md, input int t);
    int per_b;
    int mx;
    int p;
    int duty;
    int cmp;
    per_b = 1 << BW;
    mx    = (1 << DW) - 1;
    case (md)
      0: return 1'b0;
      1: return 1'b1;
      2: return (t % per_b) < (per_b / 2);
      default: begin
        p    = t % (2 * mx);
        duty = (p <= mx) ? p : 2 * mx - p;
        cmp  = duty >> (DW - CW);
`ifdef LED_GAMMA_EN
        cmp  = (cmp * cmp) >> CW;
`endif
        return (t % (1 << CW)) < cmp;
      end
    endcase
  endfunction

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int fld(input logic [7:0] m, input int k);
    return int'((m >> (2 * k)) & 8'h3);
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    int low;
    low = lowest(bus.i_req);
    if (rst) begin
      m_g = -1; m_h = 0; m_t = 0; m_led = 1'b0;
    end else if (m_g < 0) begin
      m_led = 1'b0;
      if (bus.i_en && low >= 0) begin
        m_g = low; m_h = HOLD - 1; m_t = 0;
      end
    end else if (!bus.i_en || !bus.i_req[m_g]) begin
      m_led = 1'b0;
      m_g   = -1;
    end else if (m_h == 0 && low < m_g) begin
      m_led = 1'b0;
      m_g = low; m_h = HOLD - 1; m_t = 0;
    end else begin
      m_led = ref_pat(fld(bus.i_mode, m_g), m_t);
      m_t++;
      if (m_h > 0) m_h--;
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [3:0] q, input logic [7:0] md);
    exp_t x;
    @(posedge clk);
    model_step();
    #1;
    rst        = r;
    bus.i_en   = e;
    bus.i_req  = q;
    bus.i_mode = md;
    x.grant = (m_g >= 0) ? 4'(1 << m_g) : 4'd0;
    x.busy  = (m_g >= 0);
    x.mode  = (m_g >= 0) ? 2'(fld(md, m_g)) : 2'd0;
    x.led   = m_led;
    sb_q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("grant", 8'(bus.o_grant), 8'(x.grant));
        check("busy",  8'(bus.o_busy),  8'(x.busy));
        check("mode",  8'(bus.o_mode),  8'(x.mode));
        check("led",   8'(bus.o_led),   8'(x.led));
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int cycles;
    int len;
    logic [3:0] q;
    logic [7:0] md;
    bit e;
    bus.i_en   = 1'b0;
    bus.i_req  = '0;
    bus.i_mode = '0;

    repeat (2) drive(1'b1, 1'b0, 4'b0000, 8'h00);
    // req2 ON, then req0 BLINK waits out the hold time.
    repeat (3)  drive(1'b0, 1'b1, 4'b0100, 8'h10);
    repeat (30) drive(1'b0, 1'b1, 4'b0101, 8'h12);
    // Drop req0 with req1 pending; req3 must not preempt req1.
    repeat (10) drive(1'b0, 1'b1, 4'b0011, 8'h06);
    repeat (30) drive(1'b0, 1'b1, 4'b1010, 8'hC6);
    // req1 BREATH alone over a full ramp, then reset mid-ramp and enable drop.
    repeat (140) drive(1'b0, 1'b1, 4'b0010, 8'h0C);
    repeat (2)   drive(1'b1, 1'b1, 4'b0010, 8'h0C);
    repeat (40)  drive(1'b0, 1'b1, 4'b0010, 8'h0C);
    repeat (5)   drive(1'b0, 1'b0, 4'b0010, 8'h0C);
    repeat (5)   drive(1'b0, 1'b1, 4'b0010, 8'h0C);

    cycles = 0;
    while (cycles < 5000) begin
      len = $urandom_range(1, 160);
      q   = 4'($urandom_range(0, 15));
      md  = 8'($urandom);
      e   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) md = 8'hFF;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 15) == 0) md = 8'($urandom);
        drive(($urandom_range(0, 199) == 0), e, q, md);
      end
      cycles += len;
    end

    drive(1'b0, 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    #1;
    check("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_share_ctrl.md
Name: led_share_ctrl

Overview:
- Arbitrates one board LED among NUM_REQ device-manager requesters using fixed priority with a minimum hold time.
- Generates the granted requester's pattern: off, on, blink or breathe (triangular PWM ramp).
- Sits in the device manager between status sources (reset done, cart loaded, error, activity) and the LED pin.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is highest priority
CNT_W, 8, PWM counter width; PWM period 2^CNT_W cycles
DUTY_W, 21, breath ramp counter width (DUTY_W > CNT_W)
BLINK_W, 24, blink counter width; blink period 2^BLINK_W cycles
HOLD_CYC, 65536, minimum cycles a grant is held before preemption (>=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  global enable; low forces release
i_req  in  NUM_REQ  per-requester LED request, level
i_mode  in  2*NUM_REQ  per-requester mode; bits [2k+1:2k] belong to requester k
o_grant  out  NUM_REQ  one-hot grant, registered
o_busy  out  1  any grant active
o_mode  out  2  mode currently driven (0 when idle)
o_led  out  1  LED drive, 1 = lit, registered

Behaviour:
- Reset (i_rst high at an edge): next cycle o_grant=0, o_busy=0, o_mode=0, o_led=0; all counters 0; state IDLE. This applies at any point, including mid-grant.
- Modes (live-sampled from the granted requester each cycle): 0 OFF = LED 0; 1 ON = LED 1; 2 BLINK; 3 BREATH.
- State IDLE:
  - When i_en=1 and i_req!=0, grant the lowest set index k: o_grant=1<<k at the next edge.
  - Load hold counter with HOLD_CYC-1, clear pattern counters, go to ACTIVE.
- State ACTIVE (grant k):
  - Hold counter decrements to 0 and saturates there.
  - i_en=0 or i_req[k]=0 → IDLE next edge (o_grant=0). A new grant is issued no earlier than one cycle later.
  - Hold counter==0 and a higher-priority i_req[j] (j<k) set → switch directly to the lowest such j in one edge. Reload hold counter, clear pattern counters.
  - Lower-priority requests never preempt.
  - Release takes precedence over preemption when both apply in the same cycle.
- Latency:
  - Request at cycle N → o_grant at N+1.
  - o_led reflects the new pattern at N+2, because o_led is registered from the pattern state.
- BLINK: BLINK_W counter free-runs from 0 at grant. Pattern = ~cnt[MSB], so the LED is lit for the first half-period. Wraps naturally.
- BREATH:
  - Duty ramp starts at 0, direction up, +1 per cycle.
  - On reaching 2^DUTY_W-1, direction flips down in the same cycle. On reaching 0, direction flips up.
  - Sequence 0,1,…,max,max-1,…,0,1; period 2*(2^DUTY_W-1).
  - PWM counter (CNT_W) free-runs. Pattern = pwm_cnt < duty[DUTY_W-1 -: CNT_W].
  - Maximum duty is (2^CNT_W-1)/2^CNT_W; the LED is never fully lit in BREATH.
- Mode change while granted: pattern counters keep running and the new mode's pattern applies the next cycle.
- IDLE: pattern forced to 0.

Optional Feature:
- LED_GAMMA_EN defined: the BREATH compare value is (d*d)>>CNT_W with d = duty[DUTY_W-1 -: CNT_W], giving perceptual gamma correction. Computed combinationally, so latency is unchanged.
- Undefined: linear compare value d.
- The other modes are unaffected either way.

Decomposition:
- Package led_share_pkg holds:
  - mode constants LED_OFF=2'd0, LED_ON=2'd1, LED_BLINK=2'd2, LED_BREATH=2'd3
  - state encoding ST_IDLE, ST_ACTIVE
  - mode field width 2
- Sub-module led_pattern_gen:
  - Inputs: clear and mode. Output: pattern bit.
  - Contains the blink, ramp and PWM counters plus the gamma option.
- Arbiter FSM and hold counter stay in the top level.

Test Plan (CNT_W=4, DUTY_W=6, BLINK_W=3, HOLD_CYC=8):
- Reset, then i_en=1, i_req=4'b0100, mode2=ON at cycle 0 → o_grant=0100 at 1, o_led=1 at 2, o_mode=1.
- Grant on req2, assert req0 (BLINK) at cycle 3 → grant holds until hold expires; o_grant=0001 exactly 8 cycles after first grant. o_led then lit 4 cycles, dark 4, repeating.
- Grant req0, drop i_req[0] while req1 set → o_grant=0 for one cycle, then 0010; req3 asserted during req1's grant never preempts.
- BREATH alone on req1 → ramp reaches 63 at 63 cycles after grant and returns to 0 at 126. LED duty rises toward 15/16 and falls to 0; with LED_GAMMA_EN the mid-ramp (d=8) high count is 4 of 16 instead of 8.
- i_rst asserted mid-BREATH → next cycle all outputs 0. With requests still held, a grant reappears 1 cycle after i_rst deasserts, ramp restarting at 0.
- i_en=0 while granted, requests held → o_grant=0, o_led=0 next cycle; no grant until i_en=1.
